// File: rtl/priority_encoder_16line_4line_if.sv
// Request/grant bundle between the request sources, the encoder and the consuming sequencer.
// slave is the encoder side; master is the sources/consumer side.
interface priority_encoder_16line_4line_if;
  logic        o_en;
  logic [15:0] req;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] grant;
  logic [15:0] pending;

  modport master (
    output o_en, req, ack,
    input  code, valid, grant, pending
  );

  modport slave (
    input  o_en, req, ack,
    output code, valid, grant, pending
  );
endinterface

// File: rtl/priority_encoder_16line_4line.sv
// Registered 16-to-4 priority encoder: req->valid 2 cycles, one IDLE cycle after each ack.
// Code holds until an ack qualified by o_en; o_en hides outputs without stalling capture/arbitration.
module priority_encoder_16line_4line #(
  parameter int unsigned LOW_FIRST = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  priority_encoder_16line_4line_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] pending_q, pending_d;

  logic        eff_ack;
  logic [15:0] clr_mask;
  logic [3:0]  pick;

  // Highest-priority set bit of the registered pending vector only.
  always_comb begin
    pick = 4'd0;
    if (LOW_FIRST != 0) begin
      for (int i = 15; i >= 0; i--) begin
        if (pending_q[i]) pick = 4'(i);
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pending_q[i]) pick = 4'(i);
      end
    end
  end

  always_comb begin
    eff_ack   = bus.ack && bus.o_en && (state_q == GRANT);
    clr_mask  = eff_ack ? (16'h0001 << code_q) : 16'h0000;
    // A fresh request wins over the retire of the same line.
    pending_d = (pending_q & ~clr_mask) | bus.req;
    state_d   = state_q;
    code_d    = code_q;
    case (state_q)
      IDLE: begin
        if (pending_q != 16'h0000) begin
          code_d  = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (eff_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= 4'd0;
      pending_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    bus.valid   = (state_q == GRANT) && bus.o_en;
    bus.code    = bus.o_en ? code_q : 4'd0;
    bus.grant   = bus.valid ? (16'h0001 << code_q) : 16'h0000;
    bus.pending = pending_q;
  end

endmodule

// File: doc/priority_encoder_16line_4line.md
Name: priority_encoder_16line_4line

Overview:
- Registered 16-line-to-4-line priority encoder with a valid/ack handshake. It is the encode direction of the 4-to-16 one-hot line decoder.
- Collects request lines from up to 16 sources (control-word/interrupt sources) into a pending register.
- Presents the highest-priority pending index as a 4-bit code, holds it until acknowledged, then retires that request.
- Sits between peripheral request lines and the controller/sequencer, which consumes the code and acks.

Parameters:
- LOW_FIRST, 1, 1 = line 0 is highest priority; 0 = line 15 is highest priority.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- o_en  input  1  output enable; gates code/valid/grant and qualifies ack
- req  input  16  request lines, sampled each rising edge; any high bit sets its pending bit
- ack  input  1  consumer accepts current code (effective only when o_en=1 and valid=1)
- code  output  4  index of granted line
- valid  output  1  code is meaningful and held stable
- grant  output  16  one-hot decode of code when valid, else 16'h0000
- pending  output  16  raw pending register (not gated by o_en)

Behaviour:
- Reset (rst_n=0, asynchronous): pending=16'h0000, state=IDLE, internal code register=4'd0. Outputs: code=0, valid=0, grant=0. Reset mid-grant drops the grant immediately and clears all pending requests.
- Pending register, per edge: pending <= (pending & ~clr_mask) | req.
  - clr_mask is the one-hot of the granted index on an effective ack edge, else 0.
  - req has precedence: if req[k]=1 on the same edge as ack of line k, pending[k] stays 1.
- FSM states: IDLE, GRANT.
  - IDLE: if pending!=0 at the edge, load the code register with the highest-priority set bit of pending (per LOW_FIRST) and go to GRANT. Otherwise stay in IDLE.
  - Arbitration uses the registered pending value only. A req arriving on the same edge is not considered until the next IDLE edge.
  - GRANT: code register held constant, independent of new req (including higher-priority lines).
  - In GRANT, on an effective ack (ack=1 and o_en=1): clear pending[code] per the rule above and go to IDLE. Otherwise stay in GRANT.
- Latency:
  - req high at edge k sets pending after edge k.
  - If the FSM was in IDLE, the code loads at edge k+1 and internal valid is high after edge k+1, i.e. 2 cycles from request sample to valid.
  - After an ack at edge m, internal valid is low for exactly one cycle (IDLE). The next grant appears after edge m+1 if anything is pending.
- Output gating (combinational):
  - valid = (state==GRANT) & o_en.
  - code = o_en ? code_reg : 4'd0.
  - grant = valid ? (1<<code_reg) : 16'h0000.
- o_en=0 does not stall arbitration or pending capture. The FSM may sit in GRANT with valid hidden. ack is ignored while o_en=0.
- ack while in IDLE, or while o_en=0: no effect.
- All 16 lines requesting: grants are issued in strict priority order, one per 2 cycles if acked immediately. A line re-requested continuously starves lower lines (no fairness; intended).
- No X propagation: the code register only loads from a nonzero pending value.

Test Plan:
- Reset then idle: rst_n low→high, req=0, o_en=1, 5 cycles → valid=0, code=0, grant=0, pending=0 throughout.
- Single request, LOW_FIRST=1: req=16'h0020 pulsed one cycle, ack tied 0 → pending=16'h0020 after 1 edge, valid=1, code=5, grant=16'h0020 after 2nd edge, held 10 cycles; then ack=1 one cycle → pending=0, valid=0 next cycle.
- Priority and ordering: req=16'h8101 one cycle, ack=1 continuously, LOW_FIRST=1 → codes 0, 8, 15 each valid for one cycle with one invalid cycle between. Repeat with LOW_FIRST=0 → codes 15, 8, 0.
- Hold under preemption: grant code=9 active, then req[2]=1 before ack → code stays 9 until ack; next grant code=2.
- Simultaneous ack and re-request: in GRANT code=3, ack=1 and req[3]=1 same edge → pending[3] remains 1, valid drops one cycle, code=3 re-granted.
- o_en gating and async reset: code=4 granted, o_en=0 → code=0, valid=0, grant=0; ack=1 ignored (pending[4] stays 1); o_en=1 → code=4 reappears. Then assert rst_n=0 mid-cycle → outputs and pending zero before the next clock edge.
